qu_res_station: RTL and testbench
=================================

// Module: qu_res_station
// PURPOSE
//  Tomasulo reservation station for the Qu core. Sits between the decode/rename stage, which writes
//  res_st_cell_t-style entries, and one execution unit. Holds up to DEPTH-1 in-flight ops and snoops
//  the common data bus (CDB) to resolve operand tags. Dispatches ready ops to the execution unit.
//  An entry stays allocated until the CDB broadcasts the entry's own tag.
// PARAMETERS
//  DEPTH       RES_ST_DEPTH (32)        entries; index = tag; tag 0 reserved = "operand ready", never allocated
//  OP_WIDTH    RES_ST_OP_WIDTH (13)     width of op field
//  VDATA_WIDTH RES_ST_VDATA_WIDTH (32)  operand value width
//  ADATA_WIDTH RES_ST_ADATA_WIDTH (12)  address/immediate field width
//  ADDR_WIDTH  $clog2(DEPTH)            tag width
// PORTS
//  clk        in   1            clock; all state updates on rising edge
//  rst        in   1            asynchronous, active-high reset
//  in_valid   in   1            rename stage presents a new op
//  in_ready   out  1            a free entry exists (registered state only)
//  in_tag     out  ADDR_WIDTH   tag the op will receive if accepted (lowest free index >=1); 0 when full
//  in_op      in   OP_WIDTH     operation code
//  in_qj/qk   in   ADDR_WIDTH   producer tags of src1/src2; 0 = value valid in in_vj/in_vk
//  in_vj/vk   in   VDATA_WIDTH  operand values (used only when matching q is 0)
//  in_a       in   ADATA_WIDTH  immediate/address field
//  cdb_valid  in   1            CDB broadcast valid
//  cdb_tag    in   ADDR_WIDTH   broadcasting producer tag; tag 0 ignored
//  cdb_data   in   VDATA_WIDTH  broadcast result
//  ex_valid   out  1            a READY entry is presented
//  ex_ready   in   1            execution unit accepts
//  ex_tag     out  ADDR_WIDTH   tag of presented entry
//  ex_op      out  OP_WIDTH     op of presented entry
//  ex_vj/vk   out  VDATA_WIDTH  operand values
//  ex_a       out  ADATA_WIDTH  a field
//  occupancy  out  ADDR_WIDTH+1 number of non-FREE entries
// BEHAVIOUR
//  - Per-entry FSM: FREE -> (alloc) WAIT if qj|qk!=0 else READY; WAIT -> READY when both tags resolved;
//    READY -> ISSUED on ex handshake; ISSUED -> FREE on cdb_valid && cdb_tag==own tag.
//  - Alloc fires on in_valid&&in_ready at the edge; the entry at in_tag is written.
//  - Alloc/CDB bypass: if cdb_valid and in_qj==cdb_tag (nonzero), store vj=cdb_data, qj=0; same for qk.
//  - CDB snoop: every WAIT entry with qj==cdb_tag captures vj, clears qj; same for qk, independently.
//  - Resolution takes effect at the edge; entry is dispatchable the following cycle. Alloc with both q=0
//    at edge t gives ex_valid at cycle t+1 (1-cycle issue latency).
//  - Dispatch select: lowest-index READY entry, combinational from registered state. ex_* are stable
//    while ex_valid && !ex_ready. Fire on ex_valid&&ex_ready. At most one dispatch per cycle.
//  - Free: entry freed by CDB at edge t is allocatable from t+1; in_ready never uses same-cycle frees.
//  - Full: DEPTH-1 entries non-FREE -> in_ready=0, in_tag=0; in_valid ignored.
//  - Empty: ex_valid=0, occupancy=0.
//  - Simultaneous alloc, CDB and dispatch: all three apply in the same edge on distinct entries.
//    occupancy = old + alloc - free.
//  - CDB tag matching a FREE/WAIT/READY entry's own tag does not free it; only ISSUED entries free.
//  - Reset (async, any time, incl. mid-handshake): all entries FREE, q/v fields 0, in_ready=1,
//    in_tag=1, ex_valid=0, ex_* = 0, occupancy=0.
// CONFIGURATION
//  QU_RES_ST_FLUSH_EN defined: adds input `flush` (1 bit). flush=1 at an edge returns every entry to FREE
//    and takes priority over alloc, CDB and dispatch in that cycle. While flush=1: in_ready=0, ex_valid=0.
//  QU_RES_ST_FLUSH_EN undefined: no flush port; entries leave only via CDB free or reset.
// TESTING
//  - Reset then alloc op=5, qj=qk=0, vj=3, vk=4 -> in_tag=1; next cycle ex_valid=1, ex_tag=1,
//    ex_vj=3, ex_vk=4; ex_ready=1 -> ISSUED; cdb 1/x -> occupancy 0.
//  - Alloc qj=7 (tag 7 ISSUED), then cdb_tag=7, data=0xDEAD -> next cycle ex_valid=1, ex_vj=0xDEAD.
//  - Alloc with in_qk==cdb_tag=3 in same cycle, cdb_data=0x55 -> entry READY next cycle, ex_vk=0x55.
//  - Fill 31 entries -> in_ready=0, in_tag=0, occupancy=31; extra in_valid is dropped.
//    Free tag 4 -> in_ready=1, in_tag=4 next cycle.
//  - Two READY entries (tags 2,5), ex_ready=0 for 3 cycles -> ex_tag=2 held stable;
//    ex_ready=1 -> ex_tag=5 next cycle.
//  - Assert rst mid-operation with 10 busy entries -> immediately ex_valid=0; after release
//    occupancy=0, in_tag=1. With QU_RES_ST_FLUSH_EN: flush pulse gives the same result.

Source files
------------

// File: rtl/qu_res_station.sv
// qu_res_station: Tomasulo reservation station for the Qu core.
//   Accepts renamed ops from decode, snoops the CDB to resolve operand tags and
//   dispatches ready ops (lowest tag first) to one execution unit. An entry stays
//   allocated after issue until the CDB broadcasts its own tag.
// Ports:
//   clk, rst (async, active high)
//   in_*      : rename-side valid/ready handshake; in_tag is the tag the op will get
//   cdb_*     : common data bus broadcast (tag 0 ignored)
//   ex_*      : execution-side valid/ready handshake with operands
//   occupancy : number of non-FREE entries
// Optional build macro QU_RES_ST_FLUSH_EN adds input flush, which frees every entry.
module qu_res_station #(
    parameter int DEPTH       = 32,
    parameter int OP_WIDTH    = 13,
    parameter int VDATA_WIDTH = 32,
    parameter int ADATA_WIDTH = 12,
    parameter int ADDR_WIDTH  = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst,
`ifdef QU_RES_ST_FLUSH_EN
    input  logic                   flush,
`endif
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [ADDR_WIDTH-1:0]  in_tag,
    input  logic [OP_WIDTH-1:0]    in_op,
    input  logic [ADDR_WIDTH-1:0]  in_qj,
    input  logic [ADDR_WIDTH-1:0]  in_qk,
    input  logic [VDATA_WIDTH-1:0] in_vj,
    input  logic [VDATA_WIDTH-1:0] in_vk,
    input  logic [ADATA_WIDTH-1:0] in_a,
    input  logic                   cdb_valid,
    input  logic [ADDR_WIDTH-1:0]  cdb_tag,
    input  logic [VDATA_WIDTH-1:0] cdb_data,
    output logic                   ex_valid,
    input  logic                   ex_ready,
    output logic [ADDR_WIDTH-1:0]  ex_tag,
    output logic [OP_WIDTH-1:0]    ex_op,
    output logic [VDATA_WIDTH-1:0] ex_vj,
    output logic [VDATA_WIDTH-1:0] ex_vk,
    output logic [ADATA_WIDTH-1:0] ex_a,
    output logic [ADDR_WIDTH:0]    occupancy
);
    localparam logic [1:0] ST_FREE   = 2'd0;
    localparam logic [1:0] ST_WAIT   = 2'd1;
    localparam logic [1:0] ST_READY  = 2'd2;
    localparam logic [1:0] ST_ISSUED = 2'd3;

    logic [1:0]             st_q [DEPTH], st_d [DEPTH];
    logic [OP_WIDTH-1:0]    op_q [DEPTH], op_d [DEPTH];
    logic [ADDR_WIDTH-1:0]  qj_q [DEPTH], qj_d [DEPTH];
    logic [ADDR_WIDTH-1:0]  qk_q [DEPTH], qk_d [DEPTH];
    logic [VDATA_WIDTH-1:0] vj_q [DEPTH], vj_d [DEPTH];
    logic [VDATA_WIDTH-1:0] vk_q [DEPTH], vk_d [DEPTH];
    logic [ADATA_WIDTH-1:0] a_q  [DEPTH], a_d  [DEPTH];
    // Holds the presented entry while the execution unit stalls, so a lower
    // entry waking up cannot change ex_* mid-handshake.
    logic                   lock_q, lock_d;
    logic [ADDR_WIDTH-1:0]  lock_tag_q, lock_tag_d;

    logic                   flush_w;
    logic                   free_found, rdy_found, alloc, fire, cdb_hit;
    logic [ADDR_WIDTH-1:0]  free_idx, rdy_idx, sel;

`ifdef QU_RES_ST_FLUSH_EN
    assign flush_w = flush;
`else
    assign flush_w = 1'b0;
`endif

    // Descending scan so the last hit is the lowest index.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        rdy_found  = 1'b0;
        rdy_idx    = '0;
        occupancy  = '0;
        for (int i = DEPTH - 1; i >= 1; i--) begin
            if (st_q[i] == ST_FREE) begin
                free_found = 1'b1;
                free_idx   = ADDR_WIDTH'(i);
            end
            if (st_q[i] == ST_READY) begin
                rdy_found = 1'b1;
                rdy_idx   = ADDR_WIDTH'(i);
            end
            if (st_q[i] != ST_FREE) occupancy = occupancy + (ADDR_WIDTH+1)'(1);
        end
    end

    assign in_ready = free_found && !flush_w;
    assign in_tag   = free_found ? free_idx : '0;
    assign sel      = lock_q ? lock_tag_q : rdy_idx;
    assign ex_valid = (lock_q || rdy_found) && !flush_w;
    assign ex_tag   = ex_valid ? sel : '0;
    assign ex_op    = ex_valid ? op_q[sel] : '0;
    assign ex_vj    = ex_valid ? vj_q[sel] : '0;
    assign ex_vk    = ex_valid ? vk_q[sel] : '0;
    assign ex_a     = ex_valid ? a_q[sel] : '0;
    assign alloc    = in_valid && in_ready;
    assign fire     = ex_valid && ex_ready;
    assign cdb_hit  = cdb_valid && cdb_tag != '0;
    assign lock_d     = ex_valid && !ex_ready;
    assign lock_tag_d = sel;

    // Each entry is touched by at most one of alloc/snoop/dispatch/free per edge,
    // since those act on FREE/WAIT/READY/ISSUED entries respectively.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            st_d[i] = st_q[i];
            op_d[i] = op_q[i];
            qj_d[i] = qj_q[i];
            qk_d[i] = qk_q[i];
            vj_d[i] = vj_q[i];
            vk_d[i] = vk_q[i];
            a_d[i]  = a_q[i];
        end
        for (int i = 1; i < DEPTH; i++) begin
            if (flush_w) begin
                st_d[i] = ST_FREE;
            end else if (alloc && in_tag == ADDR_WIDTH'(i)) begin
                op_d[i] = in_op;
                a_d[i]  = in_a;
                qj_d[i] = cdb_hit && in_qj == cdb_tag ? '0 : in_qj;
                vj_d[i] = cdb_hit && in_qj == cdb_tag ? cdb_data : in_vj;
                qk_d[i] = cdb_hit && in_qk == cdb_tag ? '0 : in_qk;
                vk_d[i] = cdb_hit && in_qk == cdb_tag ? cdb_data : in_vk;
                st_d[i] = (qj_d[i] | qk_d[i]) != '0 ? ST_WAIT : ST_READY;
            end else if (st_q[i] == ST_WAIT) begin
                if (cdb_hit && qj_q[i] == cdb_tag) begin
                    qj_d[i] = '0;
                    vj_d[i] = cdb_data;
                end
                if (cdb_hit && qk_q[i] == cdb_tag) begin
                    qk_d[i] = '0;
                    vk_d[i] = cdb_data;
                end
                st_d[i] = (qj_d[i] | qk_d[i]) == '0 ? ST_READY : ST_WAIT;
            end else if (st_q[i] == ST_READY) begin
                st_d[i] = fire && sel == ADDR_WIDTH'(i) ? ST_ISSUED : ST_READY;
            end else if (st_q[i] == ST_ISSUED) begin
                st_d[i] = cdb_valid && cdb_tag == ADDR_WIDTH'(i) ? ST_FREE : ST_ISSUED;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                st_q[i] <= ST_FREE;
                op_q[i] <= '0;
                qj_q[i] <= '0;
                qk_q[i] <= '0;
                vj_q[i] <= '0;
                vk_q[i] <= '0;
                a_q[i]  <= '0;
            end
            lock_q     <= 1'b0;
            lock_tag_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                st_q[i] <= st_d[i];
                op_q[i] <= op_d[i];
                qj_q[i] <= qj_d[i];
                qk_q[i] <= qk_d[i];
                vj_q[i] <= vj_d[i];
                vk_q[i] <= vk_d[i];
                a_q[i]  <= a_d[i];
            end
            lock_q     <= lock_d;
            lock_tag_q <= lock_tag_d;
        end
    end
endmodule

// File: tb/tb_qu_res_station.sv
// tb_qu_res_station: self-checking bench for qu_res_station against a behavioural entry model.
module tb_qu_res_station;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0, in_ready;
    logic [4:0]  in_tag, in_qj = '0, in_qk = '0;
    logic [12:0] in_op = '0;
    logic [31:0] in_vj = '0, in_vk = '0;
    logic [11:0] in_a = '0;
    logic        cdb_valid = 1'b0;
    logic [4:0]  cdb_tag = '0;
    logic [31:0] cdb_data = '0;
    logic        ex_valid, ex_ready = 1'b0;
    logic [4:0]  ex_tag;
    logic [12:0] ex_op;
    logic [31:0] ex_vj, ex_vk;
    logic [11:0] ex_a;
    logic [5:0]  occupancy;

    int checks = 0;
    int errors = 0;

    // Model: 0 FREE, 1 WAIT, 2 READY, 3 ISSUED
    int          m_st [32];
    logic [12:0] m_op [32];
    logic [4:0]  m_qj [32], m_qk [32];
    logic [31:0] m_vj [32], m_vk [32];
    logic [11:0] m_a  [32];
    logic        m_hold;
    logic [4:0]  m_hold_tag;

    qu_res_station dut (
        .clk(clk), .rst(rst),
`ifdef QU_RES_ST_FLUSH_EN
        .flush(flush),
`endif
        .in_valid(in_valid), .in_ready(in_ready), .in_tag(in_tag), .in_op(in_op),
        .in_qj(in_qj), .in_qk(in_qk), .in_vj(in_vj), .in_vk(in_vk), .in_a(in_a),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_tag(ex_tag), .ex_op(ex_op),
        .ex_vj(ex_vj), .ex_vk(ex_vk), .ex_a(ex_a), .occupancy(occupancy)
    );

    initial forever #5 clk = ~clk;

    function automatic logic [4:0] exp_in_tag();
        for (int i = 1; i < 32; i++) if (m_st[i] == 0) return 5'(i);
        return 5'd0;
    endfunction

    function automatic logic [4:0] exp_ex_tag();
        if (m_hold) return m_hold_tag;
        for (int i = 1; i < 32; i++) if (m_st[i] == 2) return 5'(i);
        return 5'd0;
    endfunction

    function automatic int exp_occ();
        int n = 0;
        for (int i = 1; i < 32; i++) if (m_st[i] != 0) n++;
        return n;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_st[i] = 0; m_op[i] = '0; m_qj[i] = '0; m_qk[i] = '0;
            m_vj[i] = '0; m_vk[i] = '0; m_a[i] = '0;
        end
        m_hold = 1'b0;
        m_hold_tag = '0;
    endtask

    // Advance one clock edge and apply the same edge to the model.
    task automatic tick();
        logic [4:0] at, ft;
        logic       alloc, fire, hit;
        at = exp_in_tag();
        ft = exp_ex_tag();
        hit = cdb_valid && cdb_tag != 0;
        if (flush) begin
            for (int i = 0; i < 32; i++) m_st[i] = 0;
            m_hold = 1'b0;
        end else begin
            alloc = in_valid && at != 0;
            fire = ft != 0 && ex_ready;
            if (hit && m_st[cdb_tag] == 3) m_st[cdb_tag] = 0;
            if (fire) m_st[ft] = 3;
            for (int i = 1; i < 32; i++) begin
                if (m_st[i] == 1) begin
                    if (hit && m_qj[i] == cdb_tag) begin m_qj[i] = 0; m_vj[i] = cdb_data; end
                    if (hit && m_qk[i] == cdb_tag) begin m_qk[i] = 0; m_vk[i] = cdb_data; end
                    if (m_qj[i] == 0 && m_qk[i] == 0) m_st[i] = 2;
                end
            end
            if (alloc) begin
                m_op[at] = in_op; m_a[at] = in_a;
                m_qj[at] = (hit && in_qj == cdb_tag) ? 5'd0 : in_qj;
                m_vj[at] = (hit && in_qj == cdb_tag) ? cdb_data : in_vj;
                m_qk[at] = (hit && in_qk == cdb_tag) ? 5'd0 : in_qk;
                m_vk[at] = (hit && in_qk == cdb_tag) ? cdb_data : in_vk;
                m_st[at] = (m_qj[at] == 0 && m_qk[at] == 0) ? 2 : 1;
            end
            m_hold = ft != 0 && !ex_ready;
            m_hold_tag = ft;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_valid = 0; ex_ready = 0; cdb_valid = 0; flush = 0;
        rst = 1;
        @(posedge clk);
        #1;
        rst = 0;
        model_reset();
    endtask

    task automatic alloc_op(input logic [4:0] qj, input logic [4:0] qk,
                            input logic [31:0] vj, input logic [31:0] vk);
        in_valid = 1; in_op = 13'($urandom); in_a = 12'($urandom);
        in_qj = qj; in_qk = qk; in_vj = vj; in_vk = vk;
        tick();
        in_valid = 0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0h exp 1", in_ready); end
        checks++; if (in_tag !== 5'd1) begin errors++; $display("FAIL reset_in_tag got %0d exp 1", in_tag); end
        checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL reset_ex_valid got %0h exp 0", ex_valid); end
        checks++; if ({ex_tag, ex_op, ex_vj, ex_vk, ex_a} !== '0) begin errors++; $display("FAIL reset_ex_fields got %0h exp 0", {ex_tag, ex_op, ex_vj, ex_vk, ex_a}); end
        checks++; if (occupancy !== 6'd0) begin errors++; $display("FAIL reset_occ got %0d exp 0", occupancy); end
    endtask

    task automatic test_basic();
        do_reset();
        in_valid = 1; in_op = 13'd5; in_qj = 0; in_qk = 0; in_vj = 3; in_vk = 4; in_a = 12'h0;
        checks++; if (in_tag !== 5'd1) begin errors++; $display("FAIL basic_in_tag got %0d exp 1", in_tag); end
        tick();
        in_valid = 0;
        checks++; if (ex_valid !== 1'b1 || ex_tag !== 5'd1 || ex_op !== 13'd5) begin errors++; $display("FAIL basic_issue got v=%0h tag=%0d op=%0d exp v=1 tag=1 op=5", ex_valid, ex_tag, ex_op); end
        checks++; if (ex_vj !== 32'd3 || ex_vk !== 32'd4) begin errors++; $display("FAIL basic_operands got %0h/%0h exp 3/4", ex_vj, ex_vk); end
        ex_ready = 1;
        tick();
        ex_ready = 0;
        checks++; if (ex_valid !== 1'b0 || occupancy !== 6'd1) begin errors++; $display("FAIL basic_issued got v=%0h occ=%0d exp v=0 occ=1", ex_valid, occupancy); end
        cdb_valid = 1; cdb_tag = 1; cdb_data = $urandom;
        tick();
        cdb_valid = 0;
        checks++; if (occupancy !== 6'd0 || in_tag !== 5'd1) begin errors++; $display("FAIL basic_free got occ=%0d tag=%0d exp occ=0 tag=1", occupancy, in_tag); end
    endtask

    task automatic test_cdb_wakeup();
        do_reset();
        alloc_op(5'd7, 5'd0, 32'h0, 32'h1);
        checks++; if (ex_valid !== 1'b0 || occupancy !== 6'd1) begin errors++; $display("FAIL wake_wait got v=%0h occ=%0d exp v=0 occ=1", ex_valid, occupancy); end
        cdb_valid = 1; cdb_tag = 7; cdb_data = 32'hDEAD;
        tick();
        cdb_valid = 0;
        checks++; if (ex_valid !== 1'b1 || ex_vj !== 32'hDEAD || ex_vk !== 32'h1) begin errors++; $display("FAIL wake_ready got v=%0h vj=%0h vk=%0h exp v=1 vj=dead vk=1", ex_valid, ex_vj, ex_vk); end
    endtask

    task automatic test_bypass();
        do_reset();
        cdb_valid = 1; cdb_tag = 3; cdb_data = 32'h55;
        alloc_op(5'd0, 5'd3, 32'h9, 32'h0);
        cdb_valid = 0;
        checks++; if (ex_valid !== 1'b1 || ex_vk !== 32'h55 || ex_vj !== 32'h9) begin errors++; $display("FAIL bypass got v=%0h vj=%0h vk=%0h exp v=1 vj=9 vk=55", ex_valid, ex_vj, ex_vk); end
    endtask

    task automatic test_full();
        do_reset();
        ex_ready = 1;
        for (int i = 0; i < 31; i++) alloc_op(5'd0, 5'd0, $urandom, $urandom);
        ex_ready = 0;
        checks++; if (in_ready !== 1'b0 || in_tag !== 5'd0 || occupancy !== 6'd31) begin errors++; $display("FAIL full got rdy=%0h tag=%0d occ=%0d exp rdy=0 tag=0 occ=31", in_ready, in_tag, occupancy); end
        alloc_op(5'd0, 5'd0, 32'h1, 32'h2);
        checks++; if (occupancy !== 6'd31) begin errors++; $display("FAIL full_drop got occ=%0d exp 31", occupancy); end
        cdb_valid = 1; cdb_tag = 4; cdb_data = $urandom;
        tick();
        cdb_valid = 0;
        checks++; if (in_ready !== 1'b1 || in_tag !== 5'd4 || occupancy !== 6'd30) begin errors++; $display("FAIL full_free got rdy=%0h tag=%0d occ=%0d exp rdy=1 tag=4 occ=30", in_ready, in_tag, occupancy); end
    endtask

    task automatic test_back_to_back();
        logic [4:0] qjs [5] = '{5'd20, 5'd0, 5'd21, 5'd21, 5'd0};
        do_reset();
        for (int i = 0; i < 5; i++) alloc_op(qjs[i], 5'd0, $urandom, $urandom);
        for (int c = 0; c < 3; c++) begin
            checks++; if (ex_valid !== 1'b1 || ex_tag !== 5'd2) begin errors++; $display("FAIL stall_hold cycle %0d got v=%0h tag=%0d exp v=1 tag=2", c, ex_valid, ex_tag); end
            tick();
        end
        ex_ready = 1;
        tick();
        ex_ready = 0;
        checks++; if (ex_valid !== 1'b1 || ex_tag !== 5'd5) begin errors++; $display("FAIL stall_next got v=%0h tag=%0d exp v=1 tag=5", ex_valid, ex_tag); end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int i = 0; i < 10; i++) alloc_op(5'd0, 5'd0, $urandom, $urandom);
        ex_ready = 1;
        checks++; if (ex_valid !== 1'b1 || occupancy !== 6'd10) begin errors++; $display("FAIL areset_pre got v=%0h occ=%0d exp v=1 occ=10", ex_valid, occupancy); end
        #2;
        rst = 1;
        #1;
        checks++; if (ex_valid !== 1'b0 || occupancy !== 6'd0) begin errors++; $display("FAIL areset_now got v=%0h occ=%0d exp v=0 occ=0", ex_valid, occupancy); end
        ex_ready = 0;
        model_reset();
        @(posedge clk);
        #1;
        rst = 0;
        checks++; if (in_ready !== 1'b1 || in_tag !== 5'd1 || occupancy !== 6'd0) begin errors++; $display("FAIL areset_post got rdy=%0h tag=%0d occ=%0d exp rdy=1 tag=1 occ=0", in_ready, in_tag, occupancy); end
    endtask

`ifdef QU_RES_ST_FLUSH_EN
    task automatic test_flush();
        do_reset();
        for (int i = 0; i < 10; i++) alloc_op(5'd0, 5'($urandom_range(0, 1)), $urandom, $urandom);
        flush = 1;
        checks++; if (ex_valid !== 1'b0 || in_ready !== 1'b0) begin errors++; $display("FAIL flush_now got v=%0h rdy=%0h exp 0/0", ex_valid, in_ready); end
        tick();
        flush = 0;
        checks++; if (occupancy !== 6'd0 || in_tag !== 5'd1 || ex_valid !== 1'b0) begin errors++; $display("FAIL flush_post got occ=%0d tag=%0d v=%0h exp 0/1/0", occupancy, in_tag, ex_valid); end
    endtask
`endif

    task automatic test_random();
        logic [4:0] et;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            in_valid = $urandom_range(0, 3) != 0;
            in_op = 13'($urandom); in_a = 12'($urandom);
            in_vj = $urandom; in_vk = $urandom;
            in_qj = $urandom_range(0, 2) == 0 ? 5'($urandom_range(1, 31)) : 5'd0;
            in_qk = $urandom_range(0, 2) == 0 ? 5'($urandom_range(1, 31)) : 5'd0;
            cdb_valid = $urandom_range(0, 1) == 1;
            cdb_tag = 5'($urandom_range(0, 31));
            cdb_data = $urandom;
            for (int k = 0; k < 32; k++)
                if (m_st[k] == 3 && $urandom_range(0, 2) == 0) cdb_tag = 5'(k);
            ex_ready = $urandom_range(0, 4) < 3;
            et = exp_ex_tag();
            checks++; if (in_ready !== (exp_in_tag() != 0) || in_tag !== exp_in_tag()) begin errors++; $display("FAIL rand_in cycle %0d got rdy=%0h tag=%0d exp tag=%0d", c, in_ready, in_tag, exp_in_tag()); end
            checks++; if (occupancy !== 6'(exp_occ())) begin errors++; $display("FAIL rand_occ cycle %0d got %0d exp %0d", c, occupancy, exp_occ()); end
            checks++; if (ex_valid !== (et != 0) || ex_tag !== et) begin errors++; $display("FAIL rand_ex cycle %0d got v=%0h tag=%0d exp tag=%0d", c, ex_valid, ex_tag, et); end
            if (et != 0) begin
                checks++; if (ex_op !== m_op[et] || ex_vj !== m_vj[et] || ex_vk !== m_vk[et] || ex_a !== m_a[et]) begin errors++; $display("FAIL rand_data cycle %0d got %0h/%0h/%0h/%0h exp %0h/%0h/%0h/%0h", c, ex_op, ex_vj, ex_vk, ex_a, m_op[et], m_vj[et], m_vk[et], m_a[et]); end
            end
            tick();
        end
        in_valid = 0; cdb_valid = 0; ex_ready = 0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_basic();
        test_cdb_wakeup();
        test_bypass();
        test_full();
        test_back_to_back();
        test_async_reset();
`ifdef QU_RES_ST_FLUSH_EN
        test_flush();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
